// File: rtl/cpu_run_ctrl_if.sv
// Button/CPU-side signal bundle for the MIPS execution controller.
// The controller drives CPU_EN/CPU_RST/LEDs; the board side drives BIN and HALT.
interface cpu_run_ctrl_if;
    logic [3:0]  BIN;
    logic        HALT;
    logic        CPU_EN;
    logic        CPU_RST;
    logic        RUN;
    logic        HALTED;
    logic [1:0]  SPEED;
    logic [15:0] ICNT;

    modport master (
        input  BIN, HALT,
        output CPU_EN, CPU_RST, RUN, HALTED, SPEED, ICNT
    );

    modport slave (
        output BIN, HALT,
        input  CPU_EN, CPU_RST, RUN, HALTED, SPEED, ICNT
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the single-clock MIPS: step, free-run at four rates,
// halt-on-break and button-driven CPU reset. All outputs are registered.
module cpu_run_ctrl #(
    parameter int RATE0_DIV = 50000000,
    parameter int RATE1_DIV = 5000000,
    parameter int RATE2_DIV = 50000,
    parameter int RATE3_DIV = 1,
    parameter int CNT_W     = 26,
    parameter int RST_CYC   = 16
) (
    input  logic          CLK,
    input  logic          RST,
    cpu_run_ctrl_if.master bus
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_STOP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    logic [1:0]       state_q, state_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       speed_q, speed_d;
    logic [15:0]      icnt_q, icnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             run_q, halted_q;

    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] presc_base;
    logic             wrap;

    function automatic logic [CNT_W-1:0] rate_m1(input logic [1:0] s);
        case (s)
            2'd0:    return CNT_W'(RATE0_DIV - 1);
            2'd1:    return CNT_W'(RATE1_DIV - 1);
            2'd2:    return CNT_W'(RATE2_DIV - 1);
            default: return CNT_W'(RATE3_DIV - 1);
        endcase
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        speed_d   = speed_q + 2'(bus.BIN[2]);
        div_m1    = rate_m1(speed_d);
        // Entering run or changing speed restarts the count; the entry edge is its first tick.
        presc_base = (bus.BIN[2] || state_q != S_RUN) ? '0 : presc_q;
        wrap       = (presc_base == div_m1);

        state_d   = state_q;
        rcnt_d    = rcnt_q;
        presc_d   = '0;
        cpu_en_d  = 1'b0;
        cpu_rst_d = 1'b0;
        icnt_d    = icnt_q + 16'(cpu_en_q);

        if (bus.BIN[3]) begin
            state_d   = S_RESET;
            rcnt_d    = '0;
            cpu_rst_d = 1'b1;
            icnt_d    = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    icnt_d = '0;
                    if (rcnt_q == RC_W'(RST_CYC - 1)) begin
                        state_d = S_STOP;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d    = rcnt_q + 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
                S_STOP: begin
                    if (bus.HALT) begin
                        state_d = S_HALT;
                    end else if (bus.BIN[1]) begin
                        state_d  = S_RUN;
                        presc_d  = wrap ? '0 : presc_base + 1'b1;
                        cpu_en_d = wrap;
                    end else begin
                        cpu_en_d = bus.BIN[0];
                    end
                end
                S_RUN: begin
                    if (bus.HALT) begin
                        state_d = S_HALT;
                    end else if (bus.BIN[1]) begin
                        state_d = S_STOP;
                    end else begin
                        presc_d  = wrap ? '0 : presc_base + 1'b1;
                        cpu_en_d = wrap;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_RESET;
            rcnt_q    <= '0;
            presc_q   <= '0;
            speed_q   <= '0;
            icnt_q    <= '0;
            cpu_en_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
            run_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            presc_q   <= presc_d;
            speed_q   <= speed_d;
            icnt_q    <= icnt_d;
            cpu_en_q  <= cpu_en_d;
            cpu_rst_q <= cpu_rst_d;
            run_q     <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALT);
        end
    end

    assign bus.CPU_EN  = cpu_en_q;
    assign bus.CPU_RST = cpu_rst_q;
    assign bus.RUN     = run_q;
    assign bus.HALTED  = halted_q;
    assign bus.SPEED   = speed_q;
    assign bus.ICNT    = icnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised bench for cpu_run_ctrl: a timeline model (cycles since run/reset start)
// predicts every output; directed phases cover step, run, speed, halt, reset and ICNT wrap.
module tb_cpu_run_ctrl;

    localparam int RST_CYC = 4;
    localparam int RATE [4] = '{8, 4, 2, 1};

    logic CLK = 1'b0;
    logic RST = 1'b1;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .RATE0_DIV (8),
        .RATE1_DIV (4),
        .RATE2_DIV (2),
        .RATE3_DIV (1),
        .CNT_W     (26),
        .RST_CYC   (RST_CYC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: expected outputs for the current cycle
    typedef enum {M_RST, M_STOP, M_RUN, M_HALT} mode_t;
    mode_t       m_mode;
    int          m_rst_left;  // cycles of CPU_RST still to come, including the current one
    int          m_age;       // cycles elapsed since run started or speed changed
    int          m_speed;
    logic [15:0] m_icnt;
    bit          m_en;

    task automatic model_init();
        m_mode = M_RST; m_rst_left = RST_CYC; m_age = 0;
        m_speed = 0; m_icnt = '0; m_en = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic h);
        logic [15:0] icnt_n;
        int spd_n;
        icnt_n = m_icnt + (m_en ? 16'd1 : 16'd0);
        spd_n  = (m_speed + int'(b[2])) % 4;
        m_en   = 1'b0;
        if (b[3]) begin
            m_mode = M_RST; m_rst_left = RST_CYC; icnt_n = '0;
        end else begin
            case (m_mode)
                M_RST: begin
                    icnt_n = '0;
                    m_rst_left--;
                    if (m_rst_left == 0) m_mode = M_STOP;
                end
                M_STOP: begin
                    if (h) m_mode = M_HALT;
                    else if (b[1]) begin
                        m_mode = M_RUN; m_age = 1;
                        m_en = (m_age % RATE[spd_n]) == 0;
                    end else m_en = b[0];
                end
                M_RUN: begin
                    if (h) m_mode = M_HALT;
                    else if (b[1]) m_mode = M_STOP;
                    else begin
                        m_age = b[2] ? 1 : m_age + 1;
                        m_en = (m_age % RATE[spd_n]) == 0;
                    end
                end
                default: ;
            endcase
        end
        m_speed = spd_n;
        m_icnt  = icnt_n;
    endtask

    task automatic compare_all();
        check("CPU_EN",  32'(bus.CPU_EN),  32'(m_en));
        check("CPU_RST", 32'(bus.CPU_RST), 32'(m_mode == M_RST));
        check("RUN",     32'(bus.RUN),     32'(m_mode == M_RUN));
        check("HALTED",  32'(bus.HALTED),  32'(m_mode == M_HALT));
        check("SPEED",   32'(bus.SPEED),   32'(m_speed));
        check("ICNT",    32'(bus.ICNT),    32'(m_icnt));
    endtask

    // Entered at posedge+1: drive the cycle's inputs, compare mid-cycle, advance the model.
    task automatic tick(input logic [3:0] b, input logic h, input bit do_chk = 1'b1);
        bus.BIN  = b;
        bus.HALT = h;
        @(negedge CLK);
        if (do_chk) compare_all();
        model_step(b, h);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(4'b0000, 1'b0);
    endtask

    initial begin
        int guard;
        logic [3:0] rb;
        logic rh;

        bus.BIN  = '0;
        bus.HALT = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst CPU_RST", 32'(bus.CPU_RST), 32'd1);
        check("rst CPU_EN",  32'(bus.CPU_EN),  32'd0);
        check("rst RUN",     32'(bus.RUN),     32'd0);
        check("rst HALTED",  32'(bus.HALTED),  32'd0);
        check("rst SPEED",   32'(bus.SPEED),   32'd0);
        check("rst ICNT",    32'(bus.ICNT),    32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_init();

        // reset window, then one step
        idle(6);
        tick(4'b0001, 1'b0);
        idle(3);

        // run at speed 0, then stop
        tick(4'b0010, 1'b0);
        idle(25);
        tick(4'b0010, 1'b0);
        idle(10);

        // speed changes during run
        tick(4'b0010, 1'b0);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            tick(4'b0100, 1'b0);
            idle(3);
        end
        idle(4);
        tick(4'b0100, 1'b0);
        idle(20);

        // back to speed 3, then halt
        for (int i = 0; i < 3; i++) tick(4'b0100, 1'b0);
        idle(3);
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        idle(2);
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        idle(3);

        // reset out of halt, restarted mid-way
        tick(4'b1000, 1'b0);
        idle(2);
        tick(4'b1000, 1'b0);
        idle(6);

        // simultaneous run+step at speed 0
        tick(4'b0100, 1'b0);
        tick(4'b0011, 1'b0);
        idle(10);
        tick(4'b0010, 1'b0);
        idle(3);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rb[0] = ($urandom_range(0, 5) == 0);
            rb[1] = ($urandom_range(0, 11) == 0);
            rb[2] = ($urandom_range(0, 15) == 0);
            rb[3] = ($urandom_range(0, 63) == 0);
            rh    = ($urandom_range(0, 39) == 0);
            tick(rb, rh);
        end

        // ICNT wrap: run flat out to near 0xFFFF, then step across the wrap
        tick(4'b1000, 1'b0);
        idle(6);
        guard = 0;
        while (m_speed != 3 && guard < 4) begin
            tick(4'b0100, 1'b0);
            guard++;
        end
        tick(4'b0010, 1'b0);
        guard = 0;
        while (m_icnt != 16'hFFF0 && guard < 70000) begin
            tick(4'b0000, 1'b0, (guard % 1024) == 0);
            guard++;
        end
        check("fill budget", 32'(m_icnt), 32'h0000FFF0);
        tick(4'b0010, 1'b0);
        idle(3);
        guard = 0;
        while (m_icnt != 16'hFFFF && guard < 40) begin
            tick(4'b0001, 1'b0);
            tick(4'b0000, 1'b0);
            guard++;
        end
        check("ICNT pre-wrap", 32'(bus.ICNT), 32'h0000FFFF);
        tick(4'b0001, 1'b0);
        idle(2);
        check("ICNT wrapped", 32'(bus.ICNT), 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller for the single-clock MIPS on the DE10-Lite board.
- Consumes the four debounced one-cycle button pulses from the button input stage. Produces the CPU clock-enable, the CPU reset, the run-state indication and the speed selection.
- Supports single-step, free-run at four selectable rates, halt-on-break, and a button-driven CPU reset.

Parameters:
- RATE0_DIV, 50000000, run-mode CLK cycles per instruction at speed 0 (1 Hz @ 50 MHz)
- RATE1_DIV, 5000000, cycles per instruction at speed 1 (10 Hz)
- RATE2_DIV, 50000, cycles per instruction at speed 2 (1 kHz)
- RATE3_DIV, 1, cycles per instruction at speed 3 (every cycle)
- CNT_W, 26, prescaler width; must hold max(RATEx_DIV)-1
- RST_CYC, 16, number of cycles CPU_RST is held asserted (>=1)

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- BIN  input  4  one-cycle button pulses: [0] step, [1] run/stop toggle, [2] speed advance, [3] CPU reset
- HALT  input  1  CPU signals break/halt instruction reached (level)
- CPU_EN  output  1  one-cycle enable; the CPU commits one instruction per high cycle
- CPU_RST  output  1  active-high reset to the CPU datapath
- RUN  output  1  high while in S_RUN (LED)
- HALTED  output  1  high while in S_HALT (LED)
- SPEED  output  2  current speed index
- ICNT  output  16  instructions committed since last CPU reset

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RST is asynchronous and active-high. All registers clear on its assertion.
  - Reset values: CPU_EN=0, CPU_RST=1, RUN=0, HALTED=0, SPEED=0, ICNT=0, state=S_RESET, reset counter=0, prescaler=0.
- All outputs are registered.
- S_RESET:
  - CPU_RST=1, CPU_EN=0, ICNT held at 0.
  - The reset counter counts RST_CYC cycles. The last of those cycles is followed by S_STOP with CPU_RST=0.
  - BIN[0], BIN[1] and HALT are ignored. BIN[3] restarts the reset counter.
- S_STOP:
  - BIN[0] pulse in cycle n -> CPU_EN=1 in cycle n+1 only.
  - BIN[1] -> S_RUN. The prescaler clears on entry.
- S_RUN:
  - The prescaler increments each cycle. When it equals DIV(SPEED)-1 it wraps to 0, and CPU_EN=1 in the next cycle.
  - Consequence: the first CPU_EN occurs DIV cycles after the BIN[1] cycle. With DIV=1, CPU_EN is high every cycle.
  - BIN[1] -> S_STOP; no further CPU_EN.
  - BIN[0] is ignored.
- HALT:
  - HALT high in S_STOP or S_RUN -> S_HALT next cycle.
  - CPU_EN is forced 0 in that next cycle, even if a step or a prescaler wrap coincided.
- S_HALT:
  - CPU_EN=0, HALTED=1.
  - BIN[0] and BIN[1] are ignored. Only BIN[3] leaves.
- BIN[3], from any state:
  - Next state S_RESET, CPU_RST=1 next cycle, ICNT cleared, reset counter restarted.
- BIN[2], in any state:
  - SPEED <= SPEED+1 mod 4 (3 wraps to 0).
  - Prescaler cleared in the same cycle, so a new rate takes effect from a fresh count.
- Simultaneous events, in priority order: BIN[3] > HALT > BIN[1] > BIN[0]. BIN[2] is independent and applies in parallel.
  - Example: BIN[1] and BIN[0] together in S_STOP -> enter S_RUN, no step pulse.
- ICNT increments in the cycle CPU_EN is high (visible the following cycle). It wraps 0xFFFF -> 0x0000.
- RUN = (state==S_RUN). HALTED = (state==S_HALT). Both registered with the state.
- Multiple BIN bits may be high in one cycle. BIN is never assumed one-hot.

Test Plan (override RATE0_DIV=8, RATE1_DIV=4, RATE2_DIV=2, RATE3_DIV=1, RST_CYC=4):
- Reset and step:
  - Stimulus: assert RST, release; then BIN=0001 one cycle.
  - Required: CPU_RST=1 for exactly 4 cycles after release, then 0. The step pulse gives exactly one CPU_EN cycle, and ICNT=1.
- Run at speed 0:
  - Stimulus: from S_STOP, BIN=0010.
  - Required: RUN=1; CPU_EN every 8 cycles, first 8 cycles after the pulse. A second BIN=0010 stops the pulses, and ICNT matches the pulse count.
- Speed change:
  - Stimulus: during run, BIN=0100 three times.
  - Required: SPEED=3 and CPU_EN high every cycle. A fourth press -> SPEED=0 and 8-cycle spacing, counted from the press.
- Halt:
  - Stimulus: run at speed 3, raise HALT.
  - Required: CPU_EN=0 from the next cycle; HALTED=1, RUN=0. BIN=0001 and BIN=0010 cause no change.
- Reset out of halt:
  - Stimulus: in S_HALT, BIN=1000.
  - Required: CPU_RST=1 for 4 cycles, ICNT=0, HALTED=0, then S_STOP. Press BIN=1000 again mid-reset -> the 4-cycle count restarts.
- Simultaneous and wrap:
  - Stimulus: BIN=0011 in S_STOP; then preload ICNT near wrap by forcing 0xFFFF and step once.
  - Required: BIN=0011 -> S_RUN with no immediate CPU_EN. The step from 0xFFFF -> ICNT=0x0000.
